// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, valid/ready holding register.
// Latency ~2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles from start edge; overruns drop the new byte.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                 state, state_n;
  logic [TW-1:0]          tick, tick_n;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   rx_meta, rx_s;
  logic                   frame_good, frame_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      tick    <= tick_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_n     = tick;
    bit_n      = bit_cnt;
    shreg_n    = shreg;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          tick_n  = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in so short glitches are rejected silently.
        if (tick == TICK_HALF) begin
          if (!rx_s) begin
            state_n = DATA;
            tick_n  = '0;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      DATA: begin
        if (tick == TICK_LAST) begin
          tick_n  = '0;
          shreg_n = DATA_BITS'({rx_s, shreg} >> 1);
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state_n = STOP;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      STOP: begin
        if (tick == TICK_LAST) begin
          tick_n = '0;
          if (rx_s) begin
            frame_good = 1'b1;
            state_n    = IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_n    = BREAK;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      framing_err <= frame_bad;
      overrun_err <= 1'b0;
      if (frame_good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames plus randomized frames checked
// against an event-level model of the holding register (good/bad frame, drain, overrun).
module tb_uart_rx_deserializer;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int N   = 2 + CPB / 2 + (DB + 1) * CPB;

  logic          clk = 1'b0;
  logic          reset, rx, rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid, framing_err, overrun_err, busy;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .framing_err(framing_err),
    .overrun_err(overrun_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, fe_cnt = 0, ov_cnt = 0, vrise_cnt = 0, t_rise = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 1 unit after posedge, so at negedge they are what the next edge will use.
  always @(negedge clk) begin
    if (framing_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (rx_valid && !prev_valid) begin
      vrise_cnt++;
      t_rise = cyc;
    end
    prev_valid = rx_valid;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    step(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  int fe0, ov0, vr0, g0, t0;
  logic [7:0] exp_q[$];
  logic [7:0] hold_byte, b;
  logic       hold_full, stop;
  int         exp_fe, exp_ov;

  initial begin
    reset = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    step(3);
    reset = 1'b0;
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_fe", 32'(framing_err), 0);
    chk("rst_ov", 32'(overrun_err), 0);
    chk("rst_busy", 32'(busy), 0);
    step(4);

    // 1: single good frame, latency
    fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vrise_cnt; t0 = cyc;
    send_frame(8'h55, 1'b1);
    chk("t1_data", 32'(rx_data), 32'h55);
    chk("t1_valid", 32'(rx_valid), 1);
    chk("t1_lat", 32'((t_rise - t0 >= N + 1) && (t_rise - t0 <= N + 3)), 1);
    chk("t1_err", fe_cnt - fe0 + ov_cnt - ov0, 0);
    chk("t1_busy", 32'(busy), 0);
    g0 = got_q.size();
    drain();
    chk("t1_drain_valid", 32'(rx_valid), 0);
    chk("t1_drain_data", 32'(rx_data), 32'h55);
    chk("t1_drain_got", got_q.size() - g0, 1);
    if (got_q.size() > g0) chk("t1_drain_byte", 32'(got_q[g0]), 32'h55);

    // 2: short glitch rejected
    fe0 = fe_cnt; vr0 = vrise_cnt;
    rx = 1'b0; step(4); rx = 1'b1;
    step(2);
    chk("t2_busy_mid", 32'(busy), 1);
    step(8);
    chk("t2_busy_after", 32'(busy), 0);
    step(CPB * 10);
    chk("t2_valid", vrise_cnt - vr0, 0);
    chk("t2_fe", fe_cnt - fe0, 0);

    // 3: bad stop bit with held-low line, then recovery
    fe0 = fe_cnt; vr0 = vrise_cnt;
    send_frame(8'hA3, 1'b0);
    step(40);
    chk("t3_busy_break", 32'(busy), 1);
    rx = 1'b1;
    step(4);
    chk("t3_fe", fe_cnt - fe0, 1);
    chk("t3_valid", 32'(rx_valid), 0);
    chk("t3_busy_idle", 32'(busy), 0);
    send_frame(8'h3C, 1'b1);
    chk("t3_data", 32'(rx_data), 32'h3C);
    chk("t3_vrise", vrise_cnt - vr0, 1);
    drain();

    // 4: overrun
    ov0 = ov_cnt;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    chk("t4_data", 32'(rx_data), 32'h12);
    chk("t4_valid", 32'(rx_valid), 1);
    chk("t4_ov", ov_cnt - ov0, 1);
    drain();

    // 5: back-to-back with ready held high
    fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vrise_cnt; g0 = got_q.size();
    rx_ready = 1'b1;
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    send_frame(8'hFF, 1'b1);
    step(2);
    rx_ready = 1'b0;
    chk("t5_vrise", vrise_cnt - vr0, 3);
    chk("t5_got", got_q.size() - g0, 3);
    if (got_q.size() >= g0 + 3) begin
      chk("t5_b0", 32'(got_q[g0]), 32'h01);
      chk("t5_b1", 32'(got_q[g0+1]), 32'h80);
      chk("t5_b2", 32'(got_q[g0+2]), 32'hFF);
    end
    chk("t5_err", fe_cnt - fe0 + ov_cnt - ov0, 0);

    // 6: reset during data bit 4
    fe0 = fe_cnt; vr0 = vrise_cnt;
    b = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    step(8);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t6_data", 32'(rx_data), 0);
    chk("t6_valid", 32'(rx_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    rx = 1'b1;
    step(3 * CPB);
    chk("t6_noflag", fe_cnt - fe0 + vrise_cnt - vr0, 0);
    send_frame(8'h0F, 1'b1);
    chk("t6_next", 32'(rx_data), 32'h0F);
    drain();

    // Random frames against the holding-register model
    fe0 = fe_cnt; ov0 = ov_cnt; g0 = got_q.size();
    hold_full = 1'b0; hold_byte = 8'h00; exp_fe = 0; exp_ov = 0;
    for (int f = 0; f < 24; f++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, stop);
      if (!stop) begin
        exp_fe++;
        rx = 1'b0;
        step($urandom_range(0, 20));
        send_bit(1'b1);
        send_bit(1'b1);
      end else if (hold_full) begin
        exp_ov++;
      end else begin
        hold_full = 1'b1;
        hold_byte = b;
      end
      rx = 1'b1;
      step(CPB * $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        drain();
        if (hold_full) exp_q.push_back(hold_byte);
        hold_full = 1'b0;
      end
    end
    chk("rnd_valid", 32'(rx_valid), 32'(hold_full));
    if (hold_full) chk("rnd_hold", 32'(rx_data), 32'(hold_byte));
    chk("rnd_fe", fe_cnt - fe0, exp_fe);
    chk("rnd_ov", ov_cnt - ov0, exp_ov);
    chk("rnd_count", got_q.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (g0 + i < got_q.size()) chk("rnd_byte", 32'(got_q[g0+i]), 32'(exp_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
